cg_sram_memory: RTL

Single-port synchronous SRAM target that implements the memory side of the `cg_memory_interface` read/write channels. It is connected directly downstream of any master driving the interface (fetch unit, load/store unit). It arbitrates read and write requests onto one array port with fairness. Read data returns through a 2-entry response buffer, so `rdata_ready` backpressure never drops data.

---
 rtl/cg_mem_pkg.sv | 24 ++
 rtl/cg_resp_fifo.sv | 61 ++++++
 rtl/cg_sram_memory.sv | 110 +++++++++++
 3 files changed

// File: rtl/cg_mem_pkg.sv
// Shared types and helpers for the cg_sram_memory slice: grant encoding and
// byte-address to word-index conversion.
package cg_mem_pkg;

  // Index geometry for the default 32-bit x 1024-word configuration.
  localparam int unsigned LSB   = 2;
  localparam int unsigned IDX_W = 10;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } cg_grant_e;

  // Drops the byte-offset bits, then keeps idx_w bits so upper address bits alias.
  function automatic logic [31:0] cg_word_index(input logic [63:0]  addr,
                                                input int unsigned lsb,
                                                input int unsigned idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return 32'((addr >> lsb) & mask);
  endfunction

endpackage

// File: rtl/cg_resp_fifo.sv
// Two-entry in-order response FIFO with valid/ready on both sides; o_count
// exposes occupancy so the producer can run credit-based flow control.
module cg_resp_fifo #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push_valid,
  output logic                  o_push_ready,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  output logic                  o_pop_valid,
  input  logic                  i_pop_ready,
  output logic [DATA_WIDTH-1:0] o_pop_data,
  output logic [1:0]            o_count
);

  logic [DATA_WIDTH-1:0] data_q [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  push, pop;

  assign o_push_ready = (count_q != 2'd2);
  assign o_pop_valid  = (count_q != 2'd0);
  assign o_pop_data   = data_q[rd_ptr_q];
  assign o_count      = count_q;

  assign push = i_push_valid & o_push_ready;
  assign pop  = o_pop_valid & i_pop_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge i_clk) begin
    if (push) data_q[wr_ptr_q] <= i_push_data;
  end

endmodule

// File: rtl/cg_sram_memory.sv
// Single-port SRAM target for the cg_memory_interface: fair read/write
// arbitration onto one array port, reads returned through a 2-entry buffer.
module cg_sram_memory
  import cg_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_raddr_valid,
  output logic                  o_raddr_ready,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic                  o_rdata_valid,
  input  logic                  i_rdata_ready,
  output logic [DATA_WIDTH-1:0] o_rdata,
  input  logic                  i_wdata_valid,
  output logic                  o_wdata_ready,
  input  logic                  i_wen,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata
);

  localparam int unsigned ADDR_LSB = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IDX_BITS = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  inflight_q;
  logic                  prio_wr_q, prio_wr_d;
  cg_grant_e             gnt;

  logic [IDX_BITS-1:0]   ridx, widx;
  logic                  pop, rd_elig, wr_elig;
  logic                  fifo_push, fifo_push_ready, fifo_valid, fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic [1:0]            fifo_count;

  assign ridx = IDX_BITS'(cg_word_index(64'(i_raddr), ADDR_LSB, IDX_BITS));
  assign widx = IDX_BITS'(cg_word_index(64'(i_waddr), ADDR_LSB, IDX_BITS));

  // The in-flight word counts as a buffer entry and is presented directly when
  // the FIFO is empty, which gives single-cycle read latency.
  assign o_rdata_valid = fifo_valid | inflight_q;
  assign o_rdata       = i_rst ? '0 : (fifo_valid ? fifo_data : rd_data_q);
  assign pop           = o_rdata_valid & i_rdata_ready;
  assign fifo_pop      = fifo_valid & i_rdata_ready;
  assign fifo_push     = inflight_q & ~(~fifo_valid & i_rdata_ready);

  // Credit: occupancy + in-flight - pop < 2, rearranged to avoid underflow.
  assign rd_elig = i_raddr_valid &
                   (({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  assign wr_elig = i_wdata_valid;

  always_comb begin
    gnt       = GNT_NONE;
    prio_wr_d = prio_wr_q;
    if (!i_rst) begin
      if (rd_elig && wr_elig) begin
        gnt       = prio_wr_q ? GNT_WR : GNT_RD;
        prio_wr_d = ~prio_wr_q;
      end else if (rd_elig) begin
        gnt = GNT_RD;
      end else if (wr_elig) begin
        gnt = GNT_WR;
      end
    end
  end

  assign o_raddr_ready = (gnt == GNT_RD);
  assign o_wdata_ready = (gnt == GNT_WR);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prio_wr_q  <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      prio_wr_q  <= prio_wr_d;
      inflight_q <= (gnt == GNT_RD);
    end
  end

  // One array access per cycle; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (gnt == GNT_WR && i_wen) begin
      mem[widx] <= i_wdata;
    end else if (gnt == GNT_RD) begin
      rd_data_q <= mem[ridx];
    end
  end

  cg_resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_resp_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push_valid (fifo_push),
    .o_push_ready (fifo_push_ready),
    .i_push_data  (rd_data_q),
    .o_pop_valid  (fifo_valid),
    .i_pop_ready  (fifo_pop),
    .o_pop_data   (fifo_data),
    .o_count      (fifo_count)
  );

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
                                  fifo_push |-> fifo_push_ready);

endmodule
